// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: fetch FSM encoding, the bubble word and
// instruction field bit positions.
package fetch_stage_pkg;

   localparam int FETCH_ST_BIT = 2;

   typedef enum logic [FETCH_ST_BIT-1:0] {
      FETCH_ST_BOOT   = 2'd0,
      FETCH_ST_RUN    = 2'd1,
      FETCH_ST_HALTED = 2'd2
   } fetch_st_e;

   // sll $0,$0,0 -- an all-zero word is an architectural nop
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;
   localparam int RD_MSB     = 15;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_MSB  = 10;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;
   localparam int IMM16_MSB  = 15;
   localparam int IMM26_MSB  = 25;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load enable and bubble-insert clear.
// Clear has priority over load; pc/pc4 simply hold on a bubble.
module fetch_stage_if_id_reg
   import fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] pc_p0,
   input  logic [31:0] pc4_p0,
   input  logic [31:0] inst_p0,
   output logic        vld_p1,
   output logic [31:0] pc_p1,
   output logic [31:0] pc4_p1,
   output logic [31:0] inst_p1
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         pc_p1   <= 32'h0;
         pc4_p1  <= 32'h0;
         inst_p1 <= NOP_INST;
      end else if (clear) begin
         vld_p1  <= 1'b0;
         inst_p1 <= NOP_INST;
      end else if (load) begin
         vld_p1  <= 1'b1;
         pc_p1   <= pc_p0;
         pc4_p1  <= pc4_p0;
         inst_p1 <= inst_p0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, BOOT/RUN/HALTED control.
// Optional macro FETCH_PERF_CNT_EN adds fetched/stall performance counters.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          IM_ADDR_BIT = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   flush,
   input  logic                   redirect_en,
   input  logic [31:0]            redirect_pc,
   input  logic                   halt_req,
   input  logic                   resume,
   output logic [IM_ADDR_BIT-1:0] im_addr,
   input  logic [31:0]            im_data,
   output logic [31:0]            pc,
   output logic                   id_valid,
   output logic [31:0]            id_pc,
   output logic [31:0]            id_pc4,
   output logic [31:0]            id_inst,
   output logic [5:0]             id_opcode,
   output logic [4:0]             id_rs,
   output logic [4:0]             id_rt,
   output logic [4:0]             id_rd,
   output logic [4:0]             id_shamt,
   output logic [5:0]             id_funct,
   output logic [15:0]            id_imm16,
   output logic [25:0]            id_imm26,
   output logic                   halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]            perf_fetched,
   output logic [31:0]            perf_stall
`endif
);

   fetch_st_e   state, state_nxt;
   logic [31:0] pc_nxt;
   logic [31:0] pc4;
   logic        id_load;
   logic        id_clear;

   assign pc4     = pc + 32'd4;
   assign im_addr = pc[IM_ADDR_BIT+1:2];
   assign halted  = (state == FETCH_ST_HALTED);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH_ST_BOOT;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   // Priority in RUN: halt > redirect > stall (flush only bubbles) > flush > fetch
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      id_load   = 1'b0;
      id_clear  = 1'b0;
      case (state)
         FETCH_ST_BOOT: begin
            state_nxt = FETCH_ST_RUN;
            id_clear  = 1'b1;
         end
         FETCH_ST_RUN: begin
            if (halt_req) begin
               state_nxt = FETCH_ST_HALTED;
               id_clear  = 1'b1;
            end else if (redirect_en) begin
               pc_nxt   = redirect_pc & ~32'h3;
               id_clear = 1'b1;
            end else if (stall) begin
               id_clear = flush;
            end else if (flush) begin
               pc_nxt   = pc4;
               id_clear = 1'b1;
            end else begin
               pc_nxt  = pc4;
               id_load = 1'b1;
            end
         end
         FETCH_ST_HALTED: begin
            if (resume) state_nxt = FETCH_ST_RUN;
         end
         default: state_nxt = FETCH_ST_BOOT;
      endcase
   end

   // IF (p0) -> ID (p1) boundary
   fetch_stage_if_id_reg u_if_id_reg (
      .clk     (clk),
      .rst     (rst),
      .load    (id_load),
      .clear   (id_clear),
      .pc_p0   (pc),
      .pc4_p0  (pc4),
      .inst_p0 (im_data),
      .vld_p1  (id_valid),
      .pc_p1   (id_pc),
      .pc4_p1  (id_pc4),
      .inst_p1 (id_inst)
   );

   assign id_opcode = id_inst[OPCODE_MSB:OPCODE_LSB];
   assign id_rs     = id_inst[RS_MSB:RS_LSB];
   assign id_rt     = id_inst[RT_MSB:RT_LSB];
   assign id_rd     = id_inst[RD_MSB:RD_LSB];
   assign id_shamt  = id_inst[SHAMT_MSB:SHAMT_LSB];
   assign id_funct  = id_inst[FUNCT_MSB:FUNCT_LSB];
   assign id_imm16  = id_inst[IMM16_MSB:0];
   assign id_imm26  = id_inst[IMM26_MSB:0];

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= 32'h0;
         perf_stall   <= 32'h0;
      end else begin
         if (id_load) perf_fetched <= perf_fetched + 32'd1;
         if (state == FETCH_ST_RUN && stall && !redirect_en)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory word k = {16'hC0DE, 6'b0, k}.
`timescale 1ns/1ps
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, redirect_en, halt_req, resume;
   logic [31:0] redirect_pc;
   logic [9:0]  im_addr;
   logic [31:0] im_data;
   logic [31:0] pc, id_pc, id_pc4, id_inst;
   logic        id_valid, halted;
   logic [5:0]  id_opcode, id_funct;
   logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
   logic [15:0] id_imm16;
   logic [25:0] id_imm26;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_stall;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign im_data = {16'hC0DE, 6'b0, im_addr};

   fetch_stage #(.RESET_PC(32'h0000_0000), .IM_ADDR_BIT(10)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .flush       (flush),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .halt_req    (halt_req),
      .resume      (resume),
      .im_addr     (im_addr),
      .im_data     (im_data),
      .pc          (pc),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .id_pc4      (id_pc4),
      .id_inst     (id_inst),
      .id_opcode   (id_opcode),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_rd       (id_rd),
      .id_shamt    (id_shamt),
      .id_funct    (id_funct),
      .id_imm16    (id_imm16),
      .id_imm26    (id_imm26),
      .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched(perf_fetched),
      .perf_stall  (perf_stall)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; flush = 0; redirect_en = 0; halt_req = 0; resume = 0;
   endtask

   initial begin
      idle();
      redirect_pc = 32'h0;
      rst = 1'b1;
      #12;
      check("rst_pc", pc, 32'h0);
      check("rst_vld", {31'b0, id_valid}, 32'h0);
      check("rst_inst", id_inst, 32'h0);
      check("rst_halted", {31'b0, halted}, 32'h0);
      check("rst_idpc4", id_pc4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      check("rst_perf_f", perf_fetched, 32'h0);
      check("rst_perf_s", perf_stall, 32'h0);
`endif
      rst = 1'b0;

      // BOOT cycle
      step();
      check("boot_pc", pc, 32'h0);
      check("boot_vld", {31'b0, id_valid}, 32'h0);

      step();
      check("f0_idpc", id_pc, 32'h0);
      check("f0_inst", id_inst, 32'hC0DE_0000);
      check("f0_vld", {31'b0, id_valid}, 32'h1);
      step();
      check("f1_idpc", id_pc, 32'h4);
      check("f1_inst", id_inst, 32'hC0DE_0001);
      step();
      check("f2_idpc", id_pc, 32'h8);
      check("f2_inst", id_inst, 32'hC0DE_0002);
      check("f2_pc4", id_pc4, 32'hC);
      step();
      check("f3_pc", pc, 32'h10);

      // stall 3 cycles at pc=0x10
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_pc", pc, 32'h10);
         check("stall_idpc", id_pc, 32'hC);
      end
      stall = 0;
      step();
      check("unstall_idpc", id_pc, 32'h10);
      check("unstall_inst", id_inst, 32'hC0DE_0004);
      check("fld_opcode", {26'b0, id_opcode}, 32'h30);
      check("fld_rs", {27'b0, id_rs}, 32'h06);
      check("fld_rt", {27'b0, id_rt}, 32'h1E);
      check("fld_rd", {27'b0, id_rd}, 32'h0);
      check("fld_shamt", {27'b0, id_shamt}, 32'h0);
      check("fld_funct", {26'b0, id_funct}, 32'h04);
      check("fld_imm16", {16'b0, id_imm16}, 32'h0004);
      check("fld_imm26", {6'b0, id_imm26}, 32'h00DE_0004);

      // redirect overrides stall
      redirect_en = 1; redirect_pc = 32'h43; stall = 1;
      step();
      idle();
      check("redir_pc", pc, 32'h40);
      check("redir_vld", {31'b0, id_valid}, 32'h0);
      check("redir_inst", id_inst, 32'h0);
      step();
      check("redir_idpc", id_pc, 32'h40);
      check("redir_idinst", id_inst, 32'hC0DE_0010);

      // flush alone, then stall+flush
      flush = 1;
      step();
      check("flush_vld", {31'b0, id_valid}, 32'h0);
      check("flush_pc", pc, 32'h48);
      stall = 1;
      step();
      check("sf_vld", {31'b0, id_valid}, 32'h0);
      check("sf_pc", pc, 32'h48);
      idle();
      step();
      check("postflush_idpc", id_pc, 32'h48);

      // halt at pc=0x20
      redirect_en = 1; redirect_pc = 32'h20;
      step();
      idle();
      halt_req = 1;
      step();
      idle();
      check("halt_flag", {31'b0, halted}, 32'h1);
      check("halt_pc", pc, 32'h20);
      check("halt_vld", {31'b0, id_valid}, 32'h0);
      redirect_en = 1; redirect_pc = 32'h100; stall = 1; flush = 1; halt_req = 1;
      step();
      idle();
      check("halt_ign_pc", pc, 32'h20);
      check("halt_ign_flag", {31'b0, halted}, 32'h1);
      resume = 1;
      step();
      idle();
      check("resume_flag", {31'b0, halted}, 32'h0);
      check("resume_pc", pc, 32'h20);
      step();
      check("resume_idpc", id_pc, 32'h20);
      check("resume_vld", {31'b0, id_valid}, 32'h1);

      // wrap-around at top of address space
      redirect_en = 1; redirect_pc = 32'hFFFF_FFFF;
      step();
      idle();
      check("wrap_pc", pc, 32'hFFFF_FFFC);
      check("wrap_imaddr", {22'b0, im_addr}, 32'h3FF);
      step();
      check("wrap_next_pc", pc, 32'h0);
      check("wrap_idpc", id_pc, 32'hFFFF_FFFC);
      check("wrap_idpc4", id_pc4, 32'h0);

      // async reset while halted and stalled
      step();
      halt_req = 1;
      step();
      halt_req = 0;
      check("pre_ar_halted", {31'b0, halted}, 32'h1);
      check("pre_ar_pc", pc, 32'h4);
      stall = 1;
      #2 rst = 1'b1;
      #1;
      check("ar_halted", {31'b0, halted}, 32'h0);
      check("ar_pc", pc, 32'h0);
      check("ar_vld", {31'b0, id_valid}, 32'h0);
      check("ar_idpc4", id_pc4, 32'h0);
      #10;
      idle();
      rst = 1'b0;
      step();
      check("reboot_vld", {31'b0, id_valid}, 32'h0);

      // five fetches then two stall cycles
      for (int i = 0; i < 5; i++) step();
      check("p_idpc", id_pc, 32'h10);
      stall = 1;
      step();
      step();
      idle();
      check("p_pc", pc, 32'h14);
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetched", perf_fetched, 32'd5);
      check("perf_stall", perf_stall, 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
